button_click_gen: RTL and testbench
===================================

Name: button_click_gen

Overview:
- Conditions one raw board push-button into clean click pulses for the calculator/control FSMs (state-advance and increment inputs).
- Pipeline: 2-flop synchronizer, then press/release debounce, then auto-repeat while the button is held.
- Output `click` is a single-`sys_clk` pulse. Consumers sample it synchronously and never use it as a clock.
- One instance per button.

Parameters:
- DEBOUNCE_CYCLES, 2500000: consecutive stable cycles required to accept a press or a release. Must be ≥1.
- REPEAT_DELAY, 25000000: cycles from the first click to the first auto-repeat click. 0 disables auto-repeat.
- REPEAT_PERIOD, 12500000: cycles between later auto-repeat clicks. Must be ≥1.
- ACTIVE_LOW, 1: 1 means `btn_in` low = pressed; 0 means high = pressed.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- sys_reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw, asynchronous, bouncing button pin.
- click  output  1  one-cycle pulse per accepted press and per auto-repeat.
- pressed  output  1  debounced button level.
- repeating  output  1  high while auto-repeat is active.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops load the not-pressed level.
  - State = IDLE, counter = 0.
  - click = 0, pressed = 0, repeating = 0.
  - Reset asserted mid-operation aborts any pending click; no click is issued on the cycle reset deasserts.
- Normalization: r = sync2 XOR ACTIVE_LOW, where 1 = pressed. All FSM decisions use r only, never `btn_in`.
- Counter: 32-bit, unsigned, cleared on every state entry.
- Outputs: all registered; no combinational path from `btn_in` to any output.
- States and transitions:
  - IDLE: if r=1, go to PRESS_DB.
  - PRESS_DB:
    - r=0: back to IDLE, no click (bounce rejected).
    - Else increment counter. When the counter reaches DEBOUNCE_CYCLES-1 with r=1: go to HELD, click=1 for 1 cycle, pressed=1.
  - HELD:
    - r=0: go to RELEASE_DB.
    - Else if REPEAT_DELAY≠0, increment counter. When it reaches REPEAT_DELAY-1: go to REPEAT, click pulse, repeating=1.
  - REPEAT:
    - r=0: go to RELEASE_DB; repeating=0 on the same edge.
    - Else increment counter. When it reaches REPEAT_PERIOD-1: click pulse, counter=0.
  - RELEASE_DB:
    - r=1: go to HELD with counter=0 and no click (release bounce). The repeat delay restarts.
    - Else increment counter. When it reaches DEBOUNCE_CYCLES-1: go to IDLE, pressed=0.
- Latency, stable press: first click is high exactly 2+DEBOUNCE_CYCLES cycles after the first edge that samples the pressed level on `btn_in`.
- Latency, pressed deassertion: 2+DEBOUNCE_CYCLES cycles after a stable release.
- Click spacing, continuous hold: REPEAT_DELAY cycles from the first click to the second click, then REPEAT_PERIOD cycles between clicks.
- `click` is never high on two consecutive cycles, including when REPEAT_PERIOD=1: the pulse cycle counts as cycle 0.
- `pressed` never toggles without a full debounce window.
- Counter never wraps. Every state clears it at its terminal value, so parameters up to 2^32-1 are legal.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1 unless stated):
1. Reset with btn_in=1, then hold btn_in=0 for 8 cycles and release → exactly one click, at cycle 6 after the first low sample. pressed rises with the click and falls 6 cycles after release.
2. btn_in low pulses of 1, 2 and 3 cycles separated by highs → no click; pressed stays 0; state returns to IDLE.
3. Hold btn_in=0 for 40 cycles → clicks at cycles 6, 16, 19, 22, 25, …; repeating=1 from cycle 16; every click is a 1-cycle pulse.
4. After an accepted press, release with 2-cycle bounces (high,high,low,low,high…) → no extra click; pressed stays 1 until 4 consecutive stable high sync samples.
5. Assert sys_reset for 1 cycle at cycle 5 of a held press → click stays 0 at cycle 6; outputs 0. With the button still held, a new click arrives 2+4 cycles after reset deasserts.
6. ACTIVE_LOW=0 with REPEAT_DELAY=0, hold btn_in=1 for 30 cycles → one click at cycle 6; repeating stays 0.

Source files
------------

// File: rtl/button_click_gen.sv
// button_click_gen: synchronizes, debounces and auto-repeats one raw push-button
// into single-cycle click pulses plus debounced pressed/repeating levels.
module button_click_gen #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2500000,
    parameter logic [31:0] REPEAT_DELAY    = 32'd25000000,
    parameter logic [31:0] REPEAT_PERIOD   = 32'd12500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic btn_in,
    output logic click,
    output logic pressed,
    output logic repeating
);
    typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB} state_t;

    localparam logic [31:0] DB_LAST = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] RD_LAST = REPEAT_DELAY - 32'd1;
    localparam logic [31:0] RP_LAST = REPEAT_PERIOD - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  sync_q;
    logic        click_q, click_d;
    logic        pressed_q, pressed_d;
    logic        repeating_q, repeating_d;
    logic        r;

    assign r = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            sync_q      <= {2{ACTIVE_LOW}};
            state_q     <= IDLE;
            cnt_q       <= '0;
            click_q     <= 1'b0;
            pressed_q   <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            click_q     <= click_d;
            pressed_q   <= pressed_d;
            repeating_q <= repeating_d;
        end
    end

    // A terminal count reached while the previous cycle already clicked holds
    // the counter, so short delays/periods still leave a gap between pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        click_d     = 1'b0;
        pressed_d   = pressed_q;
        repeating_d = repeating_q;
        case (state_q)
            IDLE: begin
                if (r) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!r) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    click_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HELD: begin
                if (!r) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else if (REPEAT_DELAY != 32'd0) begin
                    if (cnt_q == RD_LAST) begin
                        if (!click_q) begin
                            state_d     = REPEAT;
                            cnt_d       = '0;
                            click_d     = 1'b1;
                            repeating_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            REPEAT: begin
                if (!r) begin
                    state_d     = RELEASE_DB;
                    cnt_d       = '0;
                    repeating_d = 1'b0;
                end else if (cnt_q == RP_LAST) begin
                    if (!click_q) begin
                        click_d = 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RELEASE_DB: begin
                if (r) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign click     = click_q;
    assign pressed   = pressed_q;
    assign repeating = repeating_q;
endmodule

// File: tb/tb_button_click_gen.sv
// tb_button_click_gen: scoreboard bench; stimulus queues expected click cycles,
// negedge monitors pop and compare whenever a DUT presents a click.
module tb_button_click_gen;
    logic sys_clk = 1'b0;
    logic sys_reset = 1'b1;
    logic btn_a = 1'b1;
    logic btn_b = 1'b0;
    logic click_a, pressed_a, repeating_a;
    logic click_b, pressed_b, repeating_b;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int   edge_n = 0;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    int   q_a[$];
    int   q_b[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) edge_n <= edge_n + 1;

    button_click_gen #(
        .DEBOUNCE_CYCLES(32'd4), .REPEAT_DELAY(32'd10), .REPEAT_PERIOD(32'd3), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .btn_in(btn_a),
        .click(click_a), .pressed(pressed_a), .repeating(repeating_a)
    );

    button_click_gen #(
        .DEBOUNCE_CYCLES(32'd4), .REPEAT_DELAY(32'd0), .REPEAT_PERIOD(32'd3), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .btn_in(btn_b),
        .click(click_b), .pressed(pressed_b), .repeating(repeating_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic at(input int k);
        while (edge_n < k) @(negedge sys_clk);
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (click_a) begin
                check("a_click_single_cycle", int'(prev_a), 0);
                if (q_a.size() == 0) check("a_unexpected_click_edge", edge_n, -1);
                else check("a_click_edge", edge_n, q_a.pop_front());
            end
            if (click_b) begin
                check("b_click_single_cycle", int'(prev_b), 0);
                if (q_b.size() == 0) check("b_unexpected_click_edge", edge_n, -1);
                else check("b_click_edge", edge_n, q_b.pop_front());
            end
        end
        prev_a <= click_a;
        prev_b <= click_b;
    end

    initial begin
        int n0;
        bit pat[8];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge sys_clk);
        check("rst_click_a", int'(click_a), 0);
        check("rst_pressed_a", int'(pressed_a), 0);
        check("rst_repeating_a", int'(repeating_a), 0);
        check("rst_pressed_b", int'(pressed_b), 0);
        sys_reset = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge sys_clk);

        // single stable press of 8 cycles
        n0 = edge_n;
        btn_a = 1'b0;
        q_a.push_back(n0 + 7);
        at(n0 + 6);  check("t1_pressed_before", int'(pressed_a), 0);
        at(n0 + 7);  check("t1_pressed_with_click", int'(pressed_a), 1);
        at(n0 + 8);  btn_a = 1'b1;
        at(n0 + 14); check("t1_pressed_hold", int'(pressed_a), 1);
        at(n0 + 15); check("t1_pressed_fall", int'(pressed_a), 0);
        at(n0 + 20); check("t1_queue_empty", q_a.size(), 0);

        // short glitches rejected
        for (int l = 1; l <= 3; l++) begin
            btn_a = 1'b0;
            repeat (l) @(negedge sys_clk);
            btn_a = 1'b1;
            repeat (5) @(negedge sys_clk);
            check("t2_pressed_low", int'(pressed_a), 0);
        end

        // continuous hold with auto-repeat
        n0 = edge_n;
        btn_a = 1'b0;
        q_a.push_back(n0 + 7);
        q_a.push_back(n0 + 17);
        for (int c = 20; c <= 41; c += 3) q_a.push_back(n0 + c);
        at(n0 + 16); check("t3_repeating_before", int'(repeating_a), 0);
        at(n0 + 17); check("t3_repeating_rise", int'(repeating_a), 1);
        at(n0 + 40); btn_a = 1'b1;
        at(n0 + 42); check("t3_repeating_hold", int'(repeating_a), 1);
        at(n0 + 43); check("t3_repeating_fall", int'(repeating_a), 0);
        at(n0 + 46); check("t3_pressed_hold", int'(pressed_a), 1);
        at(n0 + 47); check("t3_pressed_fall", int'(pressed_a), 0);
        at(n0 + 52); check("t3_queue_empty", q_a.size(), 0);

        // release with 2-cycle bounces
        n0 = edge_n;
        btn_a = 1'b0;
        q_a.push_back(n0 + 7);
        at(n0 + 8);
        for (int i = 0; i < 8; i++) begin
            btn_a = pat[i];
            @(negedge sys_clk);
        end
        btn_a = 1'b1;
        at(n0 + 18); check("t4_pressed_bounce", int'(pressed_a), 1);
        at(n0 + 22); check("t4_pressed_late", int'(pressed_a), 1);
        at(n0 + 23); check("t4_pressed_fall", int'(pressed_a), 0);
        at(n0 + 28); check("t4_queue_empty", q_a.size(), 0);

        // reset during debounce of a held press
        n0 = edge_n;
        btn_a = 1'b0;
        at(n0 + 5);  sys_reset = 1'b1;
        at(n0 + 6);
        check("t5_rst_click", int'(click_a), 0);
        check("t5_rst_pressed", int'(pressed_a), 0);
        check("t5_rst_repeating", int'(repeating_a), 0);
        sys_reset = 1'b0;
        q_a.push_back(n0 + 13);
        at(n0 + 7);  check("t5_no_click_after_rst", int'(click_a), 0);
        at(n0 + 13); check("t5_pressed_again", int'(pressed_a), 1);
        at(n0 + 16); btn_a = 1'b1;
        at(n0 + 30);
        check("t5_pressed_fall", int'(pressed_a), 0);
        check("t5_queue_empty", q_a.size(), 0);

        // active-high button, auto-repeat disabled
        n0 = edge_n;
        btn_b = 1'b1;
        q_b.push_back(n0 + 7);
        at(n0 + 7);  check("t6_pressed", int'(pressed_b), 1);
        at(n0 + 17); check("t6_repeating_off", int'(repeating_b), 0);
        at(n0 + 30); btn_b = 1'b0;
        at(n0 + 31); check("t6_repeating_end", int'(repeating_b), 0);
        at(n0 + 36); check("t6_pressed_hold", int'(pressed_b), 1);
        at(n0 + 37); check("t6_pressed_fall", int'(pressed_b), 0);
        at(n0 + 40);
        check("t6_queue_empty", q_b.size(), 0);
        check("a_queue_final", q_a.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
